ex_muldiv: RTL



---
 rtl/ex_muldiv_pkg.sv | 40 ++++
 rtl/ex_muldiv.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared pipeline definitions for the EX-stage RV32M multiply/divide unit.
package ex_muldiv_pkg;

  localparam int unsigned MD_XLEN   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } m_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // Magnitude of a possibly-signed operand; the most negative value maps to itself.
  function automatic logic [MD_XLEN-1:0] md_abs(input logic [MD_XLEN-1:0] v,
                                                 input logic              is_signed);
    return (is_signed && v[MD_XLEN-1]) ? MD_XLEN'(-v) : v;
  endfunction

  function automatic logic [MD_XLEN-1:0] md_neg(input logic [MD_XLEN-1:0] v,
                                                 input logic              en);
    return en ? MD_XLEN'(-v) : v;
  endfunction

  function automatic logic [2*MD_XLEN-1:0] md_neg2(input logic [2*MD_XLEN-1:0] v,
                                                    input logic                en);
    return en ? (2*MD_XLEN)'(-v) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide,
// one bit per cycle, with single-cycle fast path for divide-by-zero and overflow.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = MD_XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  md_state_e        state;
  logic [CW-1:0]    cnt;
  m_op_e            op;
  logic             neg_q;
  logic             neg_r;
  logic [XLEN-1:0]  b_mag;
  logic [2*XLEN-1:0] acc;

  m_op_e            op_in;
  logic             a_signed, b_signed;
  logic             a_neg_in, b_neg_in;
  logic [XLEN-1:0]  a_mag_in, b_mag_in;
  logic             div_zero, div_ovf;
  logic [XLEN-1:0]  fast_res;

  logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
  logic [2*XLEN-1:0] acc_nxt, prod_fix;
  logic [XLEN-1:0]   res_fin;

  // Operand decode at acceptance
  always_comb begin
    op_in    = m_op_e'(i_funct3);
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_in)
      OP_MULH, OP_DIV, OP_REM: begin a_signed = 1'b1; b_signed = 1'b1; end
      OP_MULHSU:               a_signed = 1'b1;
      default:                 ;
    endcase
    a_neg_in = a_signed & i_rs1_data[XLEN-1];
    b_neg_in = b_signed & i_rs2_data[XLEN-1];
    a_mag_in = md_abs(i_rs1_data, a_signed);
    b_mag_in = md_abs(i_rs2_data, b_signed);
    div_zero = i_funct3[2] & (i_rs2_data == '0);
    div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (i_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2_data == '1);
    if (div_zero)
      fast_res = ((op_in == OP_DIV) || (op_in == OP_DIVU)) ? '1 : i_rs1_data;
    else
      fast_res = (op_in == OP_DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
  end

  // One iteration: acc = {hi, lo}; multiply shifts the multiplier out of lo,
  // divide shifts the dividend out of lo while quotient bits shift in.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
    rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    rem_diff = rem_sh - {1'b0, b_mag};
    if (op[2]) begin
      if (rem_diff[XLEN]) acc_nxt = {rem_sh[XLEN-1:0],   acc[XLEN-2:0], 1'b0};
      else                acc_nxt = {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
    end
    prod_fix = md_neg2(acc_nxt, neg_q);
    case (op)
      OP_MUL:                      res_fin = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_fin = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             res_fin = md_neg(acc_nxt[XLEN-1:0], neg_q);
      default:                     res_fin = md_neg(acc_nxt[2*XLEN-1:XLEN], neg_r);
    endcase
  end

  always_comb begin
    o_stall = 1'b0;
    case (state)
      IDLE:    o_stall = i_start;
      CALC:    o_stall = 1'b1;
      default: o_stall = 1'b0;
    endcase
  end

  assign o_done = (state == DONE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op       <= OP_MUL;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      b_mag    <= '0;
      acc      <= '0;
      o_result <= '0;
    end else if (i_flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            op    <= op_in;
            neg_q <= a_neg_in ^ b_neg_in;
            neg_r <= a_neg_in;
            b_mag <= b_mag_in;
            acc   <= {{XLEN{1'b0}}, a_mag_in};
            cnt   <= CW'(XLEN);
            if (div_zero || div_ovf) begin
              o_result <= fast_res;
              state    <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            o_result <= res_fin;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
